pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register: the generalised successor to the fixed-field inter-stage flops. Carries an arbitrary control vector and data payload between adjacent stages with a valid/ready handshake, optional skid entry, flush, and a saturating stall counter. Instantiated between every stage pair (IF/ID, ID/EX, EX/MEM, MEM/WB); the enclosing stage packs its fields into `in_ctrl`/`in_data`.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/pipe_entry.sv | 43 ++++
 rtl/pipe_stage_reg.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and per-stage field layouts for the inter-stage pipeline registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  // IF/ID: ctrl = {predicted_taken, valid_fetch, fault, spare}, data = {instr, pc}
  localparam int IF_ID_CTRL_W     = 4;
  localparam int IF_ID_DATA_W     = 64;
  localparam int IF_ID_PC_LSB     = 0;
  localparam int IF_ID_INSTR_LSB  = 32;

  // ID/EX: ctrl = {branch, mem_read, mem_write, reg_write, mem_to_reg, alu_src, alu_op[1:0]}
  localparam int ID_EX_CTRL_W     = 8;
  localparam int ID_EX_DATA_W     = 133;
  localparam int ID_EX_RS1_LSB    = 0;
  localparam int ID_EX_RS2_LSB    = 32;
  localparam int ID_EX_IMM_LSB    = 64;
  localparam int ID_EX_PC_LSB     = 96;
  localparam int ID_EX_RD_LSB     = 128;

  // EX/MEM: ctrl = {branch, mem_read, mem_write, reg_write, mem_to_reg}
  localparam int EX_MEM_CTRL_W    = 5;
  localparam int EX_MEM_DATA_W    = 69;
  localparam int EX_MEM_ALU_LSB   = 0;
  localparam int EX_MEM_STORE_LSB = 32;
  localparam int EX_MEM_RD_LSB    = 64;

  // MEM/WB: ctrl = {reg_write, mem_to_reg}
  localparam int MEM_WB_CTRL_W    = 2;
  localparam int MEM_WB_DATA_W    = 69;
  localparam int MEM_WB_ALU_LSB   = 0;
  localparam int MEM_WB_LOAD_LSB  = 32;
  localparam int MEM_WB_RD_LSB    = 64;

endpackage

// File: rtl/pipe_entry.sv
// One enable-loaded pipeline entry; clear drops valid/ctrl but keeps the payload.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr_n,
  input  logic              i_load,
  input  logic              i_valid,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (!i_clr_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional skid entry, flush and
// a saturating count of cycles the downstream stalled a valid output.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e       r_state;
  pipe_state_e       w_state_nxt;
  logic              w_accept, w_fire;
  logic              w_main_load, w_main_clr_n, w_main_from_skid;
  logic              w_skid_load, w_skid_clr_n;
  logic              w_main_valid, w_skid_valid;
  logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl;
  logic [DATA_W-1:0] w_main_data, w_skid_data;
  logic              w_main_valid_d;
  logic [CTRL_W-1:0] w_main_ctrl_d;
  logic [DATA_W-1:0] w_main_data_d;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_accept = in_valid & in_ready;
  assign w_fire   = w_main_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_clr_n     = 1'b1;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clr_n     = 1'b1;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_main_load = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_accept && w_fire) begin
          w_main_load = 1'b1;
        end else if (w_fire) begin
          w_state_nxt  = ST_EMPTY;
          w_main_clr_n = 1'b0;
        end else if (w_accept && SKID != 0) begin
          w_state_nxt = ST_SKID;
          w_skid_load = 1'b1;
        end
      end
      ST_SKID: begin
        if (w_fire) begin
          w_state_nxt      = ST_FULL;
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_skid_clr_n     = 1'b0;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush overrides everything; clear beats load inside each entry.
    if (flush) begin
      w_state_nxt  = ST_EMPTY;
      w_main_clr_n = 1'b0;
      w_skid_clr_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  assign w_main_valid_d = w_main_from_skid ? w_skid_valid : 1'b1;
  assign w_main_ctrl_d  = w_main_from_skid ? w_skid_ctrl  : in_ctrl;
  assign w_main_data_d  = w_main_from_skid ? w_skid_data  : in_data;

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr_n (w_main_clr_n),
    .i_load  (w_main_load),
    .i_valid (w_main_valid_d),
    .i_ctrl  (w_main_ctrl_d),
    .i_data  (w_main_data_d),
    .o_valid (w_main_valid),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;

      pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr_n (w_skid_clr_n),
        .i_load  (w_skid_load),
        .i_valid (1'b1),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
      );

      // Registered ready: upstream timing never sees out_ready.
      always_ff @(posedge clk) begin
        if (!rst_n) r_in_ready <= 1'b0;
        else        r_in_ready <= (w_state_nxt != ST_SKID);
      end
      assign in_ready = r_in_ready;
    end else begin : g_noskid
      assign w_skid_valid = 1'b0;
      assign w_skid_ctrl  = '0;
      assign w_skid_data  = '0;
      assign in_ready     = ~w_main_valid | out_ready;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (w_main_valid && !out_ready && r_stall_cnt != {CNT_W{1'b1}})
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign out_valid = w_main_valid;
  assign out_ctrl  = w_main_ctrl;
  assign out_data  = w_main_data;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: instance 0 has the skid entry, instance 1 is single-entry.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [7:0]  c;
    logic [63:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        flush     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  in_ctrl   [2];
  logic [63:0] in_data   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [7:0]  out_ctrl  [2];
  logic [63:0] out_data  [2];
  logic [3:0]  stall_cnt [2];

  ent_t q0[$];
  ent_t q1[$];
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_stage_reg #(.CTRL_W(8), .DATA_W(64), .SKID(g == 0 ? 1 : 0), .CNT_W(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .flush     (flush[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_ctrl   (in_ctrl[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_ctrl  (out_ctrl[g]),
      .out_data  (out_data[g]),
      .stall_cnt (stall_cnt[g])
    );
  end

  function automatic logic [7:0] ctl(input logic [63:0] d);
    return d[7:0] ^ 8'hA5;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int k, input ent_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic qclear(input int k);
    if (k == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic [63:0] d);
    in_valid[k] = v;
    in_data[k]  = d;
    in_ctrl[k]  = ctl(d);
  endtask

  // Record what the coming edge will do to each stage, then cross the edge.
  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k] || flush[k]) qclear(k);
      else if (in_valid[k] && in_ready[k]) qpush(k, '{c: in_ctrl[k], d: in_data[k]});
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake must match the oldest expected entry.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n[k] && out_valid[k] && out_ready[k]) begin
        vectors++;
        if (qsize(k) == 0) begin
          errors++;
          $display("FAIL out%0d unexpected: got ctrl %0h data %0h expected nothing", k, out_ctrl[k], out_data[k]);
        end else begin
          ent_t e;
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          if (out_ctrl[k] !== e.c || out_data[k] !== e.d) begin
            errors++;
            $display("FAIL out%0d order: got ctrl %0h data %0h expected ctrl %0h data %0h",
                     k, out_ctrl[k], out_data[k], e.c, e.d);
          end
        end
      end else if (rst_n[k] && !out_valid[k]) begin
        vectors++;
        if (out_ctrl[k] !== 8'h00) begin
          errors++;
          $display("FAIL out%0d idle ctrl: got %0h expected 0", k, out_ctrl[k]);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; flush[k] = 1'b0; out_ready[k] = 1'b1;
      in_valid[k] = 1'b1; in_ctrl[k] = 8'hFF; in_data[k] = '1;
    end
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d out_valid", k), 64'(out_valid[k]), 64'd0);
      chk($sformatf("rst%0d out_ctrl", k),  64'(out_ctrl[k]),  64'd0);
      chk($sformatf("rst%0d out_data", k),  out_data[k],       64'd0);
      chk($sformatf("rst%0d stall_cnt", k), 64'(stall_cnt[k]), 64'd0);
    end
    chk("rst0 in_ready", 64'(in_ready[0]), 64'd0);
    chk("rst1 in_ready", 64'(in_ready[1]), 64'd1);

    for (int k = 0; k < 2; k++) begin rst_n[k] = 1'b1; drive(k, 1'b0, 64'd0); end
    #1 chk("release in_ready before edge", 64'(in_ready[0]), 64'd0);
    tick();
    chk("release in_ready after edge", 64'(in_ready[0]), 64'd1);

    // Streaming 1..16, one cycle latency, no bubbles
    for (int i = 1; i <= 16; i++) begin
      for (int k = 0; k < 2; k++) drive(k, 1'b1, 64'(i));
      tick();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("stream%0d valid %0d", k, i), 64'(out_valid[k]), 64'd1);
        chk($sformatf("stream%0d data %0d", k, i),  out_data[k],       64'(i));
      end
    end
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 64'd0);
    tick();

    // Backpressure into the skid entry
    out_ready[0] = 1'b0;
    drive(0, 1'b1, 64'd5); tick();
    drive(0, 1'b1, 64'd6); tick();
    chk("bp in_ready",  64'(in_ready[0]), 64'd0);
    chk("bp out_valid", 64'(out_valid[0]), 64'd1);
    chk("bp out_data",  out_data[0], 64'd5);
    drive(0, 1'b1, 64'd7);
    repeat (3) tick();
    chk("bp stall_cnt", 64'(stall_cnt[0]), 64'd4);
    chk("bp held data", out_data[0], 64'd5);
    out_ready[0] = 1'b1; drive(0, 1'b0, 64'd0);
    tick();
    chk("bp drain in_ready", 64'(in_ready[0]), 64'd1);
    chk("bp drain data",     out_data[0], 64'd6);
    tick();

    // Flush with skid occupied and a new offer in flight
    out_ready[0] = 1'b0;
    drive(0, 1'b1, 64'd8);  tick();
    drive(0, 1'b1, 64'd10); tick();
    drive(0, 1'b1, 64'd9);  flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    chk("flush out_valid", 64'(out_valid[0]), 64'd0);
    chk("flush out_ctrl",  64'(out_ctrl[0]),  64'd0);
    chk("flush in_ready",  64'(in_ready[0]),  64'd1);
    chk("flush data held", out_data[0], 64'd8);
    drive(0, 1'b0, 64'd0); out_ready[0] = 1'b1;
    repeat (2) tick();

    // Stall counter saturation (CNT_W=4)
    rst_n[0] = 1'b0; tick();
    rst_n[0] = 1'b1; tick();
    chk("sat start", 64'(stall_cnt[0]), 64'd0);
    out_ready[0] = 1'b0;
    drive(0, 1'b1, 64'd11); tick();
    drive(0, 1'b0, 64'd0);
    repeat (10) tick();
    chk("sat count10", 64'(stall_cnt[0]), 64'd10);
    repeat (10) tick();
    chk("sat count20", 64'(stall_cnt[0]), 64'd15);
    flush[0] = 1'b1; tick(); flush[0] = 1'b0;
    chk("sat after flush", 64'(stall_cnt[0]), 64'd15);
    chk("sat flush valid", 64'(out_valid[0]), 64'd0);
    drive(0, 1'b1, 64'd12); tick();
    drive(0, 1'b0, 64'd0);
    chk("midop held", out_data[0], 64'd12);
    rst_n[0] = 1'b0; tick();
    chk("midop rst stall",  64'(stall_cnt[0]), 64'd0);
    chk("midop rst valid",  64'(out_valid[0]), 64'd0);
    chk("midop rst data",   out_data[0], 64'd0);
    rst_n[0] = 1'b1; out_ready[0] = 1'b1; tick();

    // Single-entry mode: combinational ready, replace on fire+accept
    out_ready[1] = 1'b0;
    drive(1, 1'b1, 64'd20); tick();
    drive(1, 1'b0, 64'd0);
    #1 chk("noskid ready low", 64'(in_ready[1]), 64'd0);
    out_ready[1] = 1'b1;
    #1 chk("noskid ready high", 64'(in_ready[1]), 64'd1);
    drive(1, 1'b1, 64'd21); tick();
    chk("noskid replace valid", 64'(out_valid[1]), 64'd1);
    chk("noskid replace data",  out_data[1], 64'd21);
    drive(1, 1'b0, 64'd0);
    repeat (2) tick();

    chk("q0 drained", 64'(q0.size()), 64'd0);
    chk("q1 drained", 64'(q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
